qpi_burst_slave: RTL and testbench

QPI_BURST_SLAVE -- requirements
Module: qpi_burst_slave

---
 rtl/qpi_pkg.sv | 20 ++
 rtl/qpi_edge_sync.sv | 35 +++
 rtl/qpi_burst_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_qpi_burst_slave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpi_pkg.sv
// Shared opcodes and FSM state encoding for the QPI burst slave.
`timescale 1ns/1ps
package qpi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StRdata,
        StWdata,
        StIgnore
    } qpi_state_e;

    localparam logic [7:0] CmdRead     = 8'h03;
    localparam logic [7:0] CmdWrite    = 8'h02;
    localparam logic [7:0] CmdEnterQpi = 8'h38;
    localparam logic [7:0] CmdExitQpi  = 8'hFF;

endpackage

// File: rtl/qpi_edge_sync.sv
// Two-flop synchronisers for sck and cs with edge detection on the synchronised values.
`timescale 1ns/1ps
module qpi_edge_sync (
    input  logic main_clock,
    input  logic rst_n,
    input  logic sck,
    input  logic cs,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_level,
    output logic cs_rise,
    output logic cs_fall
);

    logic [2:0] sck_q;
    logic [2:0] cs_q;

    // cs chain resets low so a cs already held low at reset release produces no falling edge.
    always_ff @(posedge main_clock or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= '0;
            cs_q  <= '0;
        end else begin
            sck_q <= {sck_q[1:0], sck};
            cs_q  <= {cs_q[1:0], cs};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_level = cs_q[1];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];

endmodule

// File: rtl/qpi_burst_slave.sv
// SPI/QPI burst slave bridging serial read/write commands to a byte-wide host memory port.
// Define QPI_BURST_SLAVE_WRAP_EN to make burst addresses wrap within a 2^PAGE_W byte page.
`timescale 1ns/1ps
module qpi_burst_slave
    import qpi_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter int unsigned QPI_DEFAULT  = 0,
    parameter int unsigned PAGE_W       = 4
) (
    input  logic              main_clock,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              cs,
    inout  wire  [3:0]        io,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        write_data,
    output logic              write_data_flag,
    input  logic [7:0]        read_data,
    output logic              read_data_flag,
    output logic              qpi_mode
);

    localparam int unsigned DummyLast = (DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0;
    localparam int unsigned HiW       = ADDR_W - PAGE_W;

    logic sck_rise, sck_fall, cs_level, cs_rise, cs_fall;

    qpi_edge_sync u_sync (
        .main_clock (main_clock),
        .rst_n      (rst_n),
        .sck        (sck),
        .cs         (cs),
        .sck_rise   (sck_rise),
        .sck_fall   (sck_fall),
        .cs_level   (cs_level),
        .cs_rise    (cs_rise),
        .cs_fall    (cs_fall)
    );

    qpi_state_e        state;
    logic [15:0]       cnt;
    logic [7:0]        byte_sr;
    logic [ADDR_W-1:0] addr_sr;
    logic [7:0]        out_sr;
    logic [7:0]        rd_buf;
    logic              rd_cap;
    logic              is_read;
    logic              pend_valid;
    logic              pend_mode;
    logic              drive;
    logic [3:0]        io_q1, io_q2;

    // io is delayed by the same two flops as sck so samples line up with the detected edge.
    always_ff @(posedge main_clock or negedge rst_n) begin
        if (!rst_n) begin
            io_q1 <= '0;
            io_q2 <= '0;
        end else begin
            io_q1 <= io;
            io_q2 <= io_q1;
        end
    end

    logic [7:0]        byte_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [15:0]       byte_last;
    logic [15:0]       addr_last;
    logic [PAGE_W:0]   lo_inc;
    logic              carry;
    logic [HiW-1:0]    hi_inc;
    logic [ADDR_W-1:0] addr_inc;

    always_comb begin
        byte_nxt  = qpi_mode ? {byte_sr[3:0], io_q2} : {byte_sr[6:0], io_q2[0]};
        addr_nxt  = qpi_mode ? ((addr_sr << 4) | ADDR_W'(io_q2))
                             : ((addr_sr << 1) | ADDR_W'(io_q2[0]));
        byte_last = qpi_mode ? 16'd1 : 16'd7;
        addr_last = qpi_mode ? 16'(ADDR_W / 4 - 1) : 16'(ADDR_W - 1);
        lo_inc    = {1'b0, addr[PAGE_W-1:0]} + {{PAGE_W{1'b0}}, 1'b1};
`ifdef QPI_BURST_SLAVE_WRAP_EN
        carry     = 1'b0;
`else
        carry     = lo_inc[PAGE_W];
`endif
        hi_inc    = addr[ADDR_W-1:PAGE_W] + {{(HiW-1){1'b0}}, carry};
        addr_inc  = {hi_inc, lo_inc[PAGE_W-1:0]};
    end

    always_ff @(posedge main_clock or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            cnt             <= '0;
            byte_sr         <= '0;
            addr_sr         <= '0;
            out_sr          <= '0;
            rd_buf          <= '0;
            rd_cap          <= 1'b0;
            is_read         <= 1'b0;
            pend_valid      <= 1'b0;
            pend_mode       <= 1'b0;
            drive           <= 1'b0;
            addr            <= '0;
            write_data      <= '0;
            write_data_flag <= 1'b0;
            read_data_flag  <= 1'b0;
            qpi_mode        <= QPI_DEFAULT[0];
        end else begin
            read_data_flag  <= 1'b0;
            write_data_flag <= 1'b0;
            rd_cap          <= read_data_flag;
            if (rd_cap) rd_buf <= read_data;
            if (write_data_flag) addr <= addr_inc;
            // Mode change takes effect only once the commanding transaction ends.
            if (cs_rise && pend_valid) begin
                qpi_mode   <= pend_mode;
                pend_valid <= 1'b0;
            end

            if (cs_level) begin
                state <= StIdle;
                drive <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (cs_fall) begin
                            state      <= StCmd;
                            cnt        <= '0;
                            pend_valid <= 1'b0;
                        end
                    end
                    StCmd: begin
                        if (sck_rise) begin
                            byte_sr <= byte_nxt;
                            if (cnt == byte_last) begin
                                cnt <= '0;
                                case (byte_nxt)
                                    CmdRead: begin
                                        state   <= StAddr;
                                        is_read <= 1'b1;
                                    end
                                    CmdWrite: begin
                                        state   <= StAddr;
                                        is_read <= 1'b0;
                                    end
                                    CmdEnterQpi: begin
                                        state      <= StIgnore;
                                        pend_valid <= 1'b1;
                                        pend_mode  <= 1'b1;
                                    end
                                    CmdExitQpi: begin
                                        state      <= StIgnore;
                                        pend_valid <= 1'b1;
                                        pend_mode  <= 1'b0;
                                    end
                                    default: state <= StIgnore;
                                endcase
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    StAddr: begin
                        if (sck_rise) begin
                            addr_sr <= addr_nxt;
                            if (cnt == addr_last) begin
                                cnt  <= '0;
                                addr <= addr_nxt;
                                if (is_read) begin
                                    read_data_flag <= 1'b1;
                                    state <= (DUMMY_CYCLES == 0) ? StRdata : StDummy;
                                end else begin
                                    state <= StWdata;
                                end
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    StDummy: begin
                        if (sck_rise) begin
                            if (cnt == 16'(DummyLast)) begin
                                cnt   <= '0;
                                state <= StRdata;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    StRdata: begin
                        if (sck_fall) begin
                            drive <= 1'b1;
                            if (cnt == 16'd0) out_sr <= rd_buf;
                            else              out_sr <= qpi_mode ? (out_sr << 4) : (out_sr << 1);
                            // Last beat of the byte is now on the wire: prefetch the next one.
                            if (cnt == byte_last) begin
                                cnt            <= '0;
                                addr           <= addr_inc;
                                read_data_flag <= 1'b1;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    StWdata: begin
                        if (sck_rise) begin
                            byte_sr <= byte_nxt;
                            if (cnt == byte_last) begin
                                cnt             <= '0;
                                write_data      <= byte_nxt;
                                write_data_flag <= 1'b1;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    StIgnore: ;
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign io[0] = (drive && qpi_mode) ? out_sr[4] : 1'bz;
    assign io[1] = drive ? (qpi_mode ? out_sr[5] : out_sr[7]) : 1'bz;
    assign io[2] = (drive && qpi_mode) ? out_sr[6] : 1'bz;
    assign io[3] = (drive && qpi_mode) ? out_sr[7] : 1'bz;

endmodule

// File: tb/tb_qpi_burst_slave.sv
// Directed self-checking bench for qpi_burst_slave (SPI/QPI read, write, abort, mode, reset).
`timescale 1ns/1ps
module tb_qpi_burst_slave;

    logic       main_clock = 1'b0;
    logic       rst_n      = 1'b0;
    logic       sck        = 1'b0;
    logic       cs         = 1'b1;
    wire  [3:0] io;
    logic [3:0] tb_oe      = 4'h0;
    logic [3:0] tb_out     = 4'h0;
    logic [7:0] addr;
    logic [7:0] write_data;
    logic [7:0] read_data  = 8'h00;
    logic       write_data_flag;
    logic       read_data_flag;
    logic       qpi_mode;

    int n_vec = 0;
    int n_err = 0;

    assign io[0] = tb_oe[0] ? tb_out[0] : 1'bz;
    assign io[1] = tb_oe[1] ? tb_out[1] : 1'bz;
    assign io[2] = tb_oe[2] ? tb_out[2] : 1'bz;
    assign io[3] = tb_oe[3] ? tb_out[3] : 1'bz;

    qpi_burst_slave dut (
        .main_clock      (main_clock),
        .rst_n           (rst_n),
        .sck             (sck),
        .cs              (cs),
        .io              (io),
        .addr            (addr),
        .write_data      (write_data),
        .write_data_flag (write_data_flag),
        .read_data       (read_data),
        .read_data_flag  (read_data_flag),
        .qpi_mode        (qpi_mode)
    );

    always #5 main_clock = ~main_clock;

    // Flag monitor records each pulse with its address/data.
    logic [7:0]  rd_addr[$];
    logic [15:0] wr_rec[$];
    int          drv_cycles = 0;

    always @(negedge main_clock) begin
        if (read_data_flag) rd_addr.push_back(addr);
        if (write_data_flag) wr_rec.push_back({addr, write_data});
        if (dut.drive) drv_cycles = drv_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sck_cycle(input logic [3:0] val, output logic [3:0] smp);
        tb_out = val;
        #40;
        smp = io;
        sck = 1'b1;
        #40;
        sck = 1'b0;
    endtask

    task automatic send_spi(input logic [7:0] b);
        logic [3:0] s;
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, s);
    endtask

    task automatic send_qpi(input logic [7:0] b);
        logic [3:0] s;
        sck_cycle(b[7:4], s);
        sck_cycle(b[3:0], s);
    endtask

    task automatic idle_clocks(input int n);
        logic [3:0] s;
        for (int i = 0; i < n; i++) sck_cycle(4'h0, s);
    endtask

    task automatic recv_spi(output logic [7:0] b);
        logic [3:0] s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sck_cycle(4'h0, s);
            b = {b[6:0], s[1]};
        end
    endtask

    task automatic recv_qpi(output logic [7:0] b);
        logic [3:0] s1, s2;
        sck_cycle(4'h0, s1);
        sck_cycle(4'h0, s2);
        b = {s1, s2};
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        #60;
    endtask

    task automatic cs_end();
        #60;
        cs = 1'b1;
        #80;
    endtask

    initial begin
        logic [7:0] b0, b1;
        int rb, wb, db;
        logic [7:0] exp_wrap;

        // Reset state
        #33;
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_wdata", 32'(write_data), 32'h0);
        check("rst_rflag", 32'(read_data_flag), 32'h0);
        check("rst_wflag", 32'(write_data_flag), 32'h0);
        check("rst_qpi", 32'(qpi_mode), 32'h0);
        check("rst_drive", 32'(dut.drive), 32'h0);
        rst_n = 1'b1;
        #50;

        // SPI read: 0x03, addr 0xAB, 8 dummy, two bytes
        read_data = 8'hAB;
        tb_oe = 4'b0001;
        rb = rd_addr.size();
        cs_begin();
        send_spi(8'h03);
        send_spi(8'hAB);
        idle_clocks(8);
        recv_spi(b0);
        recv_spi(b1);
        cs_end();
        check("spi_rd_data", 32'({b0, b1}), 32'hABAB);
        check("spi_rd_nflags", 32'(rd_addr.size() - rb), 32'd3);
        check("spi_rd_addr0", 32'(rd_addr[rb]), 32'hAB);
        check("spi_rd_addr1", 32'(rd_addr[rb+1]), 32'hAC);
        check("spi_rd_addr2", 32'(rd_addr[rb+2]), 32'hAD);
        check("spi_rd_release", 32'(dut.drive), 32'h0);

        // SPI write: 0x02, addr 0x10, 0x5A, 0xC3
        wb = wr_rec.size();
        cs_begin();
        send_spi(8'h02);
        send_spi(8'h10);
        send_spi(8'h5A);
        send_spi(8'hC3);
        cs_end();
        check("spi_wr_nflags", 32'(wr_rec.size() - wb), 32'd2);
        check("spi_wr_0", 32'(wr_rec[wb]), 32'h105A);
        check("spi_wr_1", 32'(wr_rec[wb+1]), 32'h11C3);
        check("spi_wr_addr_after", 32'(addr), 32'h12);

        // Aborted write: 5 data bits then cs high
        wb = wr_rec.size();
        cs_begin();
        send_spi(8'h02);
        send_spi(8'h20);
        idle_clocks(5);
        cs_end();
        check("abort_noflag", 32'(wr_rec.size() - wb), 32'd0);
        cs_begin();
        send_spi(8'h02);
        send_spi(8'h30);
        send_spi(8'h77);
        cs_end();
        check("after_abort_n", 32'(wr_rec.size() - wb), 32'd1);
        check("after_abort_wr", 32'(wr_rec[wb]), 32'h3077);

        // Unknown command 0x9F then 16 sck
        rb = rd_addr.size();
        wb = wr_rec.size();
        db = drv_cycles;
        cs_begin();
        send_spi(8'h9F);
        idle_clocks(16);
        cs_end();
        check("unk_rflags", 32'(rd_addr.size() - rb), 32'd0);
        check("unk_wflags", 32'(wr_rec.size() - wb), 32'd0);
        check("unk_drive", 32'(drv_cycles - db), 32'd0);
        check("unk_qpi", 32'(qpi_mode), 32'h0);

        // Enter QPI: mode must not change until cs rises
        cs_begin();
        send_spi(8'h38);
        #60;
        check("qpi_mid_txn", 32'(qpi_mode), 32'h0);
        cs_end();
        check("qpi_enter", 32'(qpi_mode), 32'h1);

        // QPI read at 0xFE, two bytes
        read_data = 8'h3C;
        rb = rd_addr.size();
        tb_oe = 4'hF;
        cs_begin();
        send_qpi(8'h03);
        send_qpi(8'hFE);
        tb_oe = 4'h0;
        idle_clocks(8);
        recv_qpi(b0);
        recv_qpi(b1);
        cs_end();
`ifdef QPI_BURST_SLAVE_WRAP_EN
        exp_wrap = 8'hF0;
`else
        exp_wrap = 8'h00;
`endif
        check("qpi_rd_data", 32'({b0, b1}), 32'h3C3C);
        check("qpi_rd_nflags", 32'(rd_addr.size() - rb), 32'd3);
        check("qpi_rd_addr0", 32'(rd_addr[rb]), 32'hFE);
        check("qpi_rd_addr1", 32'(rd_addr[rb+1]), 32'hFF);
        check("qpi_rd_wrap", 32'(rd_addr[rb+2]), 32'(exp_wrap));

        // Exit QPI
        tb_oe = 4'hF;
        cs_begin();
        send_qpi(8'hFF);
        cs_end();
        check("qpi_exit", 32'(qpi_mode), 32'h0);

        // Reset in the middle of a QPI read data phase
        tb_oe = 4'b0001;
        cs_begin();
        send_spi(8'h38);
        cs_end();
        tb_oe = 4'hF;
        cs_begin();
        send_qpi(8'h03);
        send_qpi(8'h40);
        tb_oe = 4'h0;
        idle_clocks(9);
        #20;
        check("pre_rst_qpi", 32'(qpi_mode), 32'h1);
        check("pre_rst_drive", 32'(dut.drive), 32'h1);
        rst_n = 1'b0;
        #20;
        check("midrst_addr", 32'(addr), 32'h0);
        check("midrst_wdata", 32'(write_data), 32'h0);
        check("midrst_rflag", 32'(read_data_flag), 32'h0);
        check("midrst_wflag", 32'(write_data_flag), 32'h0);
        check("midrst_qpi", 32'(qpi_mode), 32'h0);
        check("midrst_drive", 32'(dut.drive), 32'h0);
        rst_n = 1'b1;
        rb = rd_addr.size();
        wb = wr_rec.size();
        tb_oe = 4'b0001;
        idle_clocks(12);
        #40;
        check("postrst_rflags", 32'(rd_addr.size() - rb), 32'd0);
        check("postrst_wflags", 32'(wr_rec.size() - wb), 32'd0);
        cs = 1'b1;
        #80;

        // Normal SPI write after reset
        cs_begin();
        send_spi(8'h02);
        send_spi(8'h55);
        send_spi(8'hA5);
        cs_end();
        check("postrst_wr_n", 32'(wr_rec.size() - wb), 32'd1);
        check("postrst_wr", 32'(wr_rec[wb]), 32'h55A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
